// File: rtl/inst_loader_pkg.sv
// Shared types and default sizing for the board-side instruction loader.
package inst_loader_pkg;

  typedef enum logic [1:0] {
    HI  = 2'd0,
    LO  = 2'd1,
    WR  = 2'd2,
    RUN = 2'd3
  } state_t;

  localparam int unsigned DEF_ADDR_W     = 10;
  localparam int unsigned DEF_DEB_CYCLES = 50000;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debounce counter for an active-low board key.
// Emits a one-cycle press pulse on each accepted released->pressed transition.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  logic [1:0]       sync;
  logic             deb;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronized level disagrees with the
  // accepted level, so any bounce back restarts the qualification window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      deb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw_n};
      press <= 1'b0;
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        deb   <= sync[1];
        cnt   <= '0;
        press <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Assembles 32-bit words from two switch halves and writes them to consecutive
// instruction-memory addresses, then releases the pipeline. IL_CHECKSUM_EN adds a running sum.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic              il_in_clk,
  input  logic              il_in_rst,
  input  logic [15:0]       il_in_sw,
  input  logic              il_in_key_n,
  input  logic              il_in_go_n,
  output logic [ADDR_W-1:0] il_out_addr,
  output logic [31:0]       il_out_data,
  output logic              il_out_wren,
  output logic              il_out_cpu_run,
  output logic [ADDR_W-1:0] il_out_count,
  output logic              il_out_phase,
  output logic [15:0]       il_out_sum,
  output logic [1:0]        il_out_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic              key_press;
  logic              go_press;
  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] count;
  logic [31:0]       data;
  logic              wren_q;
  logic              run_q;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_deb (
    .clk   (il_in_clk),
    .rst_n (il_in_rst),
    .raw_n (il_in_key_n),
    .press (key_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_go_deb (
    .clk   (il_in_clk),
    .rst_n (il_in_rst),
    .raw_n (il_in_go_n),
    .press (go_press)
  );

  // go is honoured only between words so a half-entered word is never dropped.
  always_comb begin
    state_next = state;
    case (state)
      HI: begin
        if (go_press)       state_next = RUN;
        else if (key_press) state_next = LO;
      end
      LO:  if (key_press) state_next = WR;
      WR:  state_next = (count == LAST_ADDR) ? RUN : HI;
      RUN: state_next = RUN;
      default: state_next = HI;
    endcase
  end

  always_ff @(posedge il_in_clk or negedge il_in_rst) begin
    if (!il_in_rst) begin
      state  <= HI;
      wren_q <= 1'b0;
      run_q  <= 1'b0;
      count  <= '0;
      data   <= '0;
    end else begin
      state  <= state_next;
      wren_q <= (state_next == WR);
      run_q  <= (state_next == RUN);
      if (state == HI && key_press && !go_press) data[31:16] <= il_in_sw;
      if (state == LO && key_press)              data[15:0]  <= il_in_sw;
      // Saturate on the last address: memory is full, no wrap back to 0.
      if (state == WR && count != LAST_ADDR)     count <= count + 1'b1;
    end
  end

`ifdef IL_CHECKSUM_EN
  logic [15:0] sum;

  always_ff @(posedge il_in_clk or negedge il_in_rst) begin
    if (!il_in_rst) begin
      sum <= '0;
    end else if (state == WR) begin
      sum <= sum + data[31:16] + data[15:0];
    end
  end

  assign il_out_sum = sum;
`else
  assign il_out_sum = '0;
`endif

  assign il_out_addr    = count;
  assign il_out_count   = count;
  assign il_out_data    = data;
  assign il_out_wren    = wren_q;
  assign il_out_cpu_run = run_q;
  assign il_out_phase   = (state == LO) || (state == WR);
  assign il_out_state   = state;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: randomized key entry against a word-level
// reference model, with a write scoreboard fed by stimulus and drained by a monitor.
module tb_inst_loader;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEB    = 4;
  localparam int unsigned HOLD   = 10;
  localparam int unsigned W      = ADDR_W + 32;
  localparam logic [ADDR_W-1:0] MAXA = '1;

  logic              clk;
  logic              rst_n;
  logic [15:0]       sw;
  logic              key_n;
  logic              go_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic              wren;
  logic              cpu_run;
  logic [ADDR_W-1:0] count;
  logic              phase;
  logic [15:0]       sum;
  logic [1:0]        dbg_state;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: a word-level view of the loader.
  logic [ADDR_W-1:0] m_count;
  logic              m_phase;
  logic              m_run;
  logic [31:0]       m_data;
  int unsigned       m_sum;

  inst_loader #(.ADDR_W(ADDR_W), .DEB_CYCLES(DEB)) dut (
    .il_in_clk      (clk),
    .il_in_rst      (rst_n),
    .il_in_sw       (sw),
    .il_in_key_n    (key_n),
    .il_in_go_n     (go_n),
    .il_out_addr    (addr),
    .il_out_data    (data),
    .il_out_wren    (wren),
    .il_out_cpu_run (cpu_run),
    .il_out_count   (count),
    .il_out_phase   (phase),
    .il_out_sum     (sum),
    .il_out_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_reset();
    m_count = '0;
    m_phase = 1'b0;
    m_run   = 1'b0;
    m_data  = '0;
    m_sum   = 0;
  endfunction

  function automatic void model_key(input logic [15:0] v);
    if (m_run) return;
    if (!m_phase) begin
      m_data[31:16] = v;
      m_phase = 1'b1;
    end else begin
      m_data[15:0] = v;
      exp_q.push_back({m_count, m_data});
      m_sum = (m_sum + m_data[31:16] + v) % 65536;
      if (m_count == MAXA) m_run = 1'b1;
      else m_count = m_count + 1'b1;
      m_phase = 1'b0;
    end
  endfunction

  function automatic void model_go();
    if (!m_run && !m_phase) m_run = 1'b1;
  endfunction

  // Driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    key_n = 1'b1;
    go_n  = 1'b1;
    sw    = '0;
    tick(3);
    check("rst_addr",  64'(addr), 64'd0);
    check("rst_data",  64'(data), 64'd0);
    check("rst_wren",  64'(wren), 64'd0);
    check("rst_run",   64'(cpu_run), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_sum",   64'(sum), 64'd0);
    rst_n = 1'b1;
    model_reset();
    tick(2);
  endtask

  task automatic press_key(input logic [15:0] v);
    model_key(v);
    sw    = v;
    key_n = 1'b0;
    tick(HOLD);
    key_n = 1'b1;
    tick(HOLD);
  endtask

  task automatic press_go();
    model_go();
    go_n = 1'b0;
    tick(HOLD);
    go_n = 1'b1;
    tick(HOLD);
  endtask

  task automatic press_both(input logic [15:0] v);
    if (!m_run) begin
      if (!m_phase) model_go();
      else model_key(v);
    end
    sw    = v;
    key_n = 1'b0;
    go_n  = 1'b0;
    tick(HOLD);
    key_n = 1'b1;
    go_n  = 1'b1;
    tick(HOLD);
  endtask

  task automatic check_state(input string tag);
    int unsigned exp_sum;
`ifdef IL_CHECKSUM_EN
    exp_sum = m_sum;
`else
    exp_sum = 0;
`endif
    check({tag, "_count"}, 64'(count), 64'(m_count));
    check({tag, "_addr"},  64'(addr), 64'(m_count));
    check({tag, "_phase"}, 64'(phase), 64'(m_phase));
    check({tag, "_run"},   64'(cpu_run), 64'(m_run));
    check({tag, "_data"},  64'(data), 64'(m_data));
    check({tag, "_sum"},   64'(sum), 64'(exp_sum));
    check({tag, "_qempty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor
  logic prev_wren = 1'b0;
  always @(negedge clk) begin
    if (rst_n && wren) begin
      check("wren_pulse", 64'(prev_wren), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'({addr, data}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", 64'({addr, data}), 64'(e));
      end
    end
    prev_wren = rst_n && wren;
  end

  initial begin
    int k;
    logic [15:0] v;
    model_reset();
    rst_n = 1'b0;
    key_n = 1'b1;
    go_n  = 1'b1;
    sw    = '0;
    tick(2);

    // Single word with press-latency measurement on the high half.
    do_reset();
    sw    = 16'h2008;
    key_n = 1'b0;
    k = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (phase) begin
        k = i;
        break;
      end
    end
    check("press_latency", 64'(k), 64'(DEB + 3));
    model_key(16'h2008);
    key_n = 1'b1;
    tick(HOLD);
    press_key(16'h0005);
    check("word0_data", 64'(data), 64'h2008_0005);
    check_state("word0");

    // Bounce: 2-cycle pulses must never qualify.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      key_n = 1'b0;
      tick(2);
      key_n = 1'b1;
      tick(3);
    end
    tick(HOLD);
    check_state("bounce");

    // Three random words, go, then presses that must be ignored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press_key(16'($urandom));
      press_key(16'($urandom));
    end
    press_go();
    check_state("go_run");
    press_key(16'($urandom));
    press_key(16'($urandom));
    check_state("run_ignore");

    // go during LO ignored; go with key in HI wins without a write.
    do_reset();
    press_key(16'($urandom));
    press_go();
    check_state("go_in_lo");
    press_key(16'($urandom));
    press_both(16'($urandom_range(0, 65535)));
    check_state("both_in_hi");

    // Fill all four addresses: auto RUN, count saturates.
    do_reset();
    press_key(16'h0001);
    press_key(16'h0002);
    press_key(16'hFFFF);
    press_key(16'h0001);
`ifdef IL_CHECKSUM_EN
    check("sum_two_words", 64'(sum), 64'h0003);
`else
    check("sum_disabled", 64'(sum), 64'h0000);
`endif
    for (int i = 0; i < 2; i++) begin
      v = 16'($urandom);
      press_key(v);
      press_key(16'($urandom));
    end
    check_state("full");
    press_key(16'($urandom));
    check_state("full_ignore");

    // Reset asserted while the write pulse is high.
    do_reset();
    press_key(16'hAAAA);
    sw    = 16'h5555;
    key_n = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (wren) begin
        k = 1;
        break;
      end
    end
    check("mid_wr_reached", 64'(k), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midwr_addr",  64'(addr), 64'd0);
    check("midwr_data",  64'(data), 64'd0);
    check("midwr_wren",  64'(wren), 64'd0);
    check("midwr_run",   64'(cpu_run), 64'd0);
    check("midwr_count", 64'(count), 64'd0);
    check("midwr_phase", 64'(phase), 64'd0);
    check("midwr_sum",   64'(sum), 64'd0);
    check("midwr_state", 64'(dbg_state), 64'd0);
    key_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    model_reset();
    tick(HOLD);
    check_state("after_midwr");

    tick(5);
    check("final_qempty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
